fnd_scan_monitor: RTL and testbench

- Receive-side counterpart of the 4-digit multiplexed FND display driver.
- Watches the scanned digit-select and segment-font lines and filters out switching glitches.
- Decodes each 7-segment font back to BCD and rebuilds the full 0-9999 value once per complete scan frame.
- Used as a self-check monitor in the top level and as a loopback source for verification.

---
 rtl/fnd_pkg.sv | 42 ++++
 rtl/fnd_settle_filter.sv | 47 ++++
 rtl/fnd_scan_monitor.sv | 174 +++++++++++++++++
 tb/tb_fnd_scan_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan monitor: active-high segment fonts, digit
// indices, monitor FSM states and the font-to-BCD decoder.
package fnd_pkg;

  localparam logic [6:0] FONT_0 = 7'h3F;
  localparam logic [6:0] FONT_1 = 7'h06;
  localparam logic [6:0] FONT_2 = 7'h5B;
  localparam logic [6:0] FONT_3 = 7'h4F;
  localparam logic [6:0] FONT_4 = 7'h66;
  localparam logic [6:0] FONT_5 = 7'h6D;
  localparam logic [6:0] FONT_6 = 7'h7D;
  localparam logic [6:0] FONT_7 = 7'h07;
  localparam logic [6:0] FONT_8 = 7'h7F;
  localparam logic [6:0] FONT_9 = 7'h6F;

  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUNDS = 2'd2;
  localparam logic [1:0] DIG_THOUS = 2'd3;

  typedef enum logic [1:0] {IDLE, COLLECT, ASSEMBLE} state_e;

  // Returns {valid, nibble}; the dp bit (bit 7) is masked off before decoding.
  function automatic logic [4:0] font_to_bcd(input logic [7:0] font);
    logic [7:0] segs;
    segs = font & 8'h7F;
    case (segs)
      {1'b0, FONT_0}: font_to_bcd = {1'b1, 4'd0};
      {1'b0, FONT_1}: font_to_bcd = {1'b1, 4'd1};
      {1'b0, FONT_2}: font_to_bcd = {1'b1, 4'd2};
      {1'b0, FONT_3}: font_to_bcd = {1'b1, 4'd3};
      {1'b0, FONT_4}: font_to_bcd = {1'b1, 4'd4};
      {1'b0, FONT_5}: font_to_bcd = {1'b1, 4'd5};
      {1'b0, FONT_6}: font_to_bcd = {1'b1, 4'd6};
      {1'b0, FONT_7}: font_to_bcd = {1'b1, 4'd7};
      {1'b0, FONT_8}: font_to_bcd = {1'b1, 4'd8};
      {1'b0, FONT_9}: font_to_bcd = {1'b1, 4'd9};
      default:        font_to_bcd = {1'b0, 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/fnd_settle_filter.sv
// Stability filter: emits a single capture pulse once its input has held still
// for SETTLE_CYCLES consecutive cycles.
module fnd_settle_filter #(
  parameter int unsigned WIDTH         = 12,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             capture_o,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [7:0] SettleMax = 8'(SETTLE_CYCLES);

  logic [WIDTH-1:0] data_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             capture_q, capture_d;

  always_comb begin
    if (data_i != data_q) begin
      cnt_d = '0;
    end else if (cnt_q == SettleMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    // Fires only on the transition into saturation, so a held pair captures once.
    capture_d = (cnt_d == SettleMax) && (cnt_q != SettleMax);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      cnt_q     <= '0;
      capture_q <= 1'b0;
    end else begin
      data_q    <= data_i;
      cnt_q     <= cnt_d;
      capture_q <= capture_d;
    end
  end

  assign capture_o = capture_q;
  assign data_o    = data_q;

endmodule

// File: rtl/fnd_scan_monitor.sv
// Receive-side monitor for a 4-digit multiplexed FND: filters the scan lines,
// decodes fonts back to BCD and publishes one 0..9999 value per complete frame.
module fnd_scan_monitor
  import fnd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 200000,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit          FONT_ACTIVE_LOW  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_digit,
  input  logic [7:0]  i_font,
  output logic [13:0] o_value,
  output logic [15:0] o_bcd,
  output logic        o_valid,
  output logic        o_changed,
  output logic        o_error,
  output logic        o_stale
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        filt_cap;
  logic [11:0] filt_data;

  assign sel = DIGIT_ACTIVE_LOW ? ~i_digit : i_digit;
  assign seg = FONT_ACTIVE_LOW ? ~i_font : i_font;

  fnd_settle_filter #(
    .WIDTH        (12),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .data_i   ({sel, seg}),
    .capture_o(filt_cap),
    .data_o   (filt_data)
  );

  state_e         state_q, state_d;
  logic [3:0]     mask_q, mask_d;
  logic [15:0]    nib_q, nib_d;
  logic           bad_q, bad_d;
  logic           pend_q, pend_d;
  logic [11:0]    pend_data_q, pend_data_d;
  logic [13:0]    value_q, value_d;
  logic [15:0]    bcd_q, bcd_d;
  logic           error_q, error_d;
  logic           stale_q, stale_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  // A capture parked during ASSEMBLE takes priority in the following IDLE cycle.
  logic        eff_cap;
  logic [11:0] eff_data;
  logic [3:0]  eff_sel;
  logic        sel_ok;
  logic [1:0]  idx;
  logic [4:0]  fb;

  assign eff_cap  = pend_q | filt_cap;
  assign eff_data = pend_q ? pend_data_q : filt_data;
  assign eff_sel  = eff_data[11:8];
  assign sel_ok   = (eff_sel != 4'd0) && ((eff_sel & (eff_sel - 4'd1)) == 4'd0);
  assign fb       = font_to_bcd(eff_data[7:0]);

  always_comb begin
    idx = DIG_ONES;
    if (eff_sel[1]) idx = DIG_TENS;
    if (eff_sel[2]) idx = DIG_HUNDS;
    if (eff_sel[3]) idx = DIG_THOUS;
  end

  // th*1000 + h*100 + t*10 + o as shifts and adds; the result never exceeds 9999.
  logic [13:0] th, hu, te, on, asm_value;
  always_comb begin
    th = {10'd0, nib_q[15:12]};
    hu = {10'd0, nib_q[11:8]};
    te = {10'd0, nib_q[7:4]};
    on = {10'd0, nib_q[3:0]};
    asm_value = (th << 9) + (th << 8) + (th << 7) + (th << 6) + (th << 5) + (th << 3)
              + (hu << 6) + (hu << 5) + (hu << 2)
              + (te << 3) + (te << 1) + on;
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    nib_d       = nib_q;
    bad_d       = bad_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    value_d     = value_q;
    bcd_d       = bcd_q;
    error_d     = error_q;
    stale_d     = stale_q;
    tmo_d       = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;

    unique case (state_q)
      IDLE, COLLECT: begin
        pend_d = 1'b0;
        if (eff_cap && sel_ok) begin
          nib_d[{idx, 2'b00} +: 4] = fb[3:0];
          mask_d[idx]              = 1'b1;
          if (!fb[4]) bad_d = 1'b1;
          state_d = (mask_d == 4'hF) ? ASSEMBLE : COLLECT;
        end
      end
      ASSEMBLE: begin
        if (filt_cap) begin
          pend_d      = 1'b1;
          pend_data_d = filt_data;
        end
        if (!bad_q) begin
          value_d = asm_value;
          bcd_d   = nib_q;
          error_d = 1'b0;
          stale_d = 1'b0;
          tmo_d   = '0;
        end else begin
          error_d = 1'b1;
        end
        mask_d  = '0;
        bad_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (tmo_d == TmoMax) stale_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      nib_q       <= '0;
      bad_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      value_q     <= '0;
      bcd_q       <= '0;
      error_q     <= 1'b0;
      stale_q     <= 1'b1;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      nib_q       <= nib_d;
      bad_q       <= bad_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      value_q     <= value_d;
      bcd_q       <= bcd_d;
      error_q     <= error_d;
      stale_q     <= stale_d;
      tmo_q       <= tmo_d;
    end
  end

  logic asm_good;
  assign asm_good  = (state_q == ASSEMBLE) && !bad_q;
  assign o_valid   = asm_good;
  assign o_changed = asm_good && (asm_value != value_q);
  assign o_value   = asm_good ? asm_value : value_q;
  assign o_bcd     = asm_good ? nib_q : bcd_q;
  assign o_error   = error_q;
  assign o_stale   = stale_q;

endmodule

// File: tb/tb_fnd_scan_monitor.sv
// Directed bench for fnd_scan_monitor (SETTLE=8, TIMEOUT=1000, active-low lines).
module tb_fnd_scan_monitor;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_digit = 4'hF;
  logic [7:0]  i_font = 8'hFF;
  logic [13:0] o_value;
  logic [15:0] o_bcd;
  logic        o_valid, o_changed, o_error, o_stale;

  int n_vec = 0;
  int n_err = 0;
  int vcount = 0;
  logic [13:0] last_value = '0;
  logic [15:0] last_bcd = '0;
  logic        last_changed = 1'b0;

  fnd_scan_monitor #(
    .SETTLE_CYCLES   (8),
    .TIMEOUT_CYCLES  (1000),
    .DIGIT_ACTIVE_LOW(1'b1),
    .FONT_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_digit  (i_digit),
    .i_font   (i_font),
    .o_value  (o_value),
    .o_bcd    (o_bcd),
    .o_valid  (o_valid),
    .o_changed(o_changed),
    .o_error  (o_error),
    .o_stale  (o_stale)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      vcount       = vcount + 1;
      last_value   = o_value;
      last_bcd     = o_bcd;
      last_changed = o_changed;
    end
  end

  task automatic drive_pair(input logic [3:0] d, input logic [7:0] f, input int n);
    @(negedge i_clk);
    i_digit = d;
    i_font  = f;
    repeat (n) @(posedge i_clk);
  endtask

  task automatic blank(input int n);
    drive_pair(4'hF, 8'hFF, n);
  endtask

  task automatic drive_frame(input logic [7:0] f0, input logic [7:0] f1,
                             input logic [7:0] f2, input logic [7:0] f3);
    drive_pair(4'b1110, f0, 20);
    drive_pair(4'b1101, f1, 20);
    drive_pair(4'b1011, f2, 20);
    drive_pair(4'b0111, f3, 20);
    blank(5);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_vec++; if (o_value !== 14'd0) begin n_err++; $display("FAIL reset value: got %0d want 0", o_value); end
    n_vec++; if (o_bcd !== 16'h0) begin n_err++; $display("FAIL reset bcd: got %h want 0000", o_bcd); end
    n_vec++; if (o_valid !== 1'b0 || o_changed !== 1'b0 || o_error !== 1'b0) begin
      n_err++; $display("FAIL reset flags: got valid=%b chg=%b err=%b want 0 0 0", o_valid, o_changed, o_error);
    end
    n_vec++; if (o_stale !== 1'b1) begin n_err++; $display("FAIL reset stale: got %b want 1", o_stale); end
    i_reset = 1'b0;
  endtask

  task automatic test_frame_1234;
    int v0;
    v0 = vcount;
    drive_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 1) begin n_err++; $display("FAIL 1234 pulses: got %0d want 1", vcount - v0); end
    n_vec++; if (last_value !== 14'd1234) begin n_err++; $display("FAIL 1234 value: got %0d want 1234", last_value); end
    n_vec++; if (last_bcd !== 16'h1234) begin n_err++; $display("FAIL 1234 bcd: got %h want 1234", last_bcd); end
    n_vec++; if (last_changed !== 1'b1) begin n_err++; $display("FAIL 1234 changed: got %b want 1", last_changed); end
    n_vec++; if (o_value !== 14'd1234 || o_stale !== 1'b0) begin
      n_err++; $display("FAIL 1234 held: got value=%0d stale=%b want 1234 0", o_value, o_stale);
    end
  endtask

  task automatic test_repeat;
    int v0;
    v0 = vcount;
    drive_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 1) begin n_err++; $display("FAIL repeat pulses: got %0d want 1", vcount - v0); end
    n_vec++; if (last_changed !== 1'b0) begin n_err++; $display("FAIL repeat changed: got %b want 0", last_changed); end
    n_vec++; if (o_value !== 14'd1234) begin n_err++; $display("FAIL repeat value: got %0d want 1234", o_value); end
  endtask

  task automatic test_glitch_9999;
    int v0;
    v0 = vcount;
    drive_pair(4'b1110, 8'hFF, 2); drive_pair(4'b1110, 8'h90, 20);
    drive_pair(4'b1101, 8'hFF, 2); drive_pair(4'b1101, 8'h90, 20);
    drive_pair(4'b1011, 8'hFF, 2); drive_pair(4'b1011, 8'h90, 20);
    // Thousands '1' held only 5 cycles must not be captured.
    drive_pair(4'b0111, 8'hFF, 2); drive_pair(4'b0111, 8'hF9, 5);
    blank(20);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 0) begin n_err++; $display("FAIL short pair pulses: got %0d want 0", vcount - v0); end
    drive_pair(4'b0111, 8'h90, 20);
    blank(5);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 1) begin n_err++; $display("FAIL 9999 pulses: got %0d want 1", vcount - v0); end
    n_vec++; if (last_value !== 14'd9999) begin n_err++; $display("FAIL 9999 value: got %0d want 9999", last_value); end
    n_vec++; if (last_bcd !== 16'h9999) begin n_err++; $display("FAIL 9999 bcd: got %h want 9999", last_bcd); end
    n_vec++; if (last_changed !== 1'b1) begin n_err++; $display("FAIL 9999 changed: got %b want 1", last_changed); end
    n_vec++; if (o_error !== 1'b0) begin n_err++; $display("FAIL 9999 error: got %b want 0", o_error); end
  endtask

  task automatic test_bad_font;
    int v0;
    v0 = vcount;
    drive_pair(4'b1110, 8'hC0, 20);
    drive_pair(4'b1101, 8'hFF, 2);
    drive_pair(4'b1101, 8'h55, 20);
    drive_pair(4'b1011, 8'hC0, 20);
    drive_pair(4'b0111, 8'hC0, 20);
    blank(5);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 0) begin n_err++; $display("FAIL bad frame pulses: got %0d want 0", vcount - v0); end
    n_vec++; if (o_error !== 1'b1) begin n_err++; $display("FAIL bad frame error: got %b want 1", o_error); end
    n_vec++; if (o_value !== 14'd9999 || o_bcd !== 16'h9999) begin
      n_err++; $display("FAIL bad frame hold: got %0d/%h want 9999/9999", o_value, o_bcd);
    end
    drive_frame(8'hF8, 8'hC0, 8'hC0, 8'hC0);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 1) begin n_err++; $display("FAIL 0007 pulses: got %0d want 1", vcount - v0); end
    n_vec++; if (o_error !== 1'b0) begin n_err++; $display("FAIL 0007 error: got %b want 0", o_error); end
    n_vec++; if (last_value !== 14'd7) begin n_err++; $display("FAIL 0007 value: got %0d want 7", last_value); end
    n_vec++; if (o_bcd !== 16'h0007) begin n_err++; $display("FAIL 0007 bcd: got %h want 0007", o_bcd); end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    drive_pair(4'b1110, 8'hA4, 20);
    drive_pair(4'b1101, 8'h99, 20);
    @(negedge i_clk);
    i_reset = 1'b1;
    i_digit = 4'hF;
    i_font  = 8'hFF;
    #1;
    n_vec++; if (o_value !== 14'd0 || o_bcd !== 16'h0) begin
      n_err++; $display("FAIL midreset data: got %0d/%h want 0/0000", o_value, o_bcd);
    end
    n_vec++; if (o_valid !== 1'b0 || o_changed !== 1'b0 || o_error !== 1'b0 || o_stale !== 1'b1) begin
      n_err++; $display("FAIL midreset flags: got v=%b c=%b e=%b s=%b want 0 0 0 1",
                        o_valid, o_changed, o_error, o_stale);
    end
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    v0 = vcount;
    // Would complete a frame if the pre-reset ones/tens had survived.
    drive_pair(4'b1011, 8'hC0, 20);
    drive_pair(4'b0111, 8'hC0, 20);
    blank(5);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 0) begin n_err++; $display("FAIL partial discard pulses: got %0d want 0", vcount - v0); end
    drive_pair(4'b1110, 8'hA4, 20);
    drive_pair(4'b1101, 8'h99, 20);
    blank(5);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 1) begin n_err++; $display("FAIL 0042 pulses: got %0d want 1", vcount - v0); end
    n_vec++; if (last_value !== 14'd42 || last_bcd !== 16'h0042) begin
      n_err++; $display("FAIL 0042 value: got %0d/%h want 42/0042", last_value, last_bcd);
    end
    n_vec++; if (o_stale !== 1'b0) begin n_err++; $display("FAIL 0042 stale: got %b want 0", o_stale); end
  endtask

  task automatic test_timeout;
    bit found;
    bit early;
    int v0;
    drive_pair(4'b1110, 8'hF9, 20);
    drive_pair(4'b1101, 8'hC0, 20);
    drive_pair(4'b1011, 8'hC0, 20);
    @(negedge i_clk);
    i_digit = 4'b0111;
    i_font  = 8'hC0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) found = 1'b1;
    end
    i_digit = 4'hF;
    i_font  = 8'hFF;
    n_vec++; if (!found) begin n_err++; $display("FAIL timeout frame: got no o_valid want pulse"); end
    n_vec++; if (o_value !== 14'd1) begin n_err++; $display("FAIL timeout frame value: got %0d want 1", o_value); end
    @(posedge i_clk);
    early = 1'b0;
    for (int i = 0; i < 999; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_stale !== 1'b0) early = 1'b1;
    end
    n_vec++; if (early) begin n_err++; $display("FAIL stale early: got 1 before 1000 cycles want 0"); end
    @(posedge i_clk);
    @(negedge i_clk);
    n_vec++; if (o_stale !== 1'b1) begin n_err++; $display("FAIL stale at 1000: got %b want 1", o_stale); end
    v0 = vcount;
    drive_frame(8'hA4, 8'h99, 8'hC0, 8'hC0);
    @(negedge i_clk);
    n_vec++; if (vcount - v0 !== 1 || o_stale !== 1'b0) begin
      n_err++; $display("FAIL stale clear: got pulses=%0d stale=%b want 1 0", vcount - v0, o_stale);
    end
  endtask

  initial begin
    test_reset();
    test_frame_1234();
    test_repeat();
    test_glitch_9999();
    test_bad_font();
    test_reset_mid_frame();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
